// File: rtl/icache_pkg.sv
// Shared instruction-memory geometry constants and ICACHE types/helpers.
// The optional ICACHE_PERF_CNT_EN macro (hit/miss counters) is consumed in icache.sv.
`ifndef ICACHE_DEFS_SVH
`define ICACHE_DEFS_SVH
`define IWORD_SIZE_BITS      32
`define IBLOCK_SIZE_WORDS    4
`define IBLOCK_SIZE_BITS     128
`define IMEM_BLOCK_ADDR_SIZE 28
`define ICACHE_INDEX_BITS    5
`define ICACHE_TAG_BITS      23
`endif

package icache_pkg;

  localparam int unsigned WORD_W      = `IWORD_SIZE_BITS;
  localparam int unsigned BLOCK_WORDS = `IBLOCK_SIZE_WORDS;
  localparam int unsigned BLOCK_W     = `IBLOCK_SIZE_BITS;
  localparam int unsigned WOFF_W      = $clog2(BLOCK_WORDS);
  localparam int unsigned BLK_ADDR_W  = `IMEM_BLOCK_ADDR_SIZE;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_MISS    = 2'd1;
  localparam state_t ST_RESPOND = 2'd2;

  function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic [WOFF_W-1:0]  off);
    return blk[int'(off)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag + block storage: one combinational read port, one write port.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned SETS  = 32,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned TAG_W = 23
) (
  input  logic               clock,
  input  logic [IDX_W-1:0]   rd_index,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_block,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_block
);

  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [BLOCK_W-1:0] data_q [SETS];

  // No reset: line contents are only meaningful behind the valid bits in the top.
  always_ff @(posedge clock) begin
    if (we) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_block;
    end
  end

  assign rd_tag   = tag_q[rd_index];
  assign rd_block = data_q[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped blocking instruction cache (IDLE/MISS/RESPOND).
// Define ICACHE_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned SETS   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cpu_ren,
  input  logic [ADDR_W-1:0]                cpu_addr,
  input  logic                             flush,
  output logic                             cpu_ready,
  output logic [`IWORD_SIZE_BITS-1:0]      cpu_dout,
  output logic                             mem_ren,
  output logic [`IMEM_BLOCK_ADDR_SIZE-1:0] mem_block_address,
  input  logic                             mem_ready,
  input  logic [`IBLOCK_SIZE_BITS-1:0]     mem_dout
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
`endif
);

  localparam int unsigned IDX_W   = $clog2(SETS);
  localparam int unsigned TAG_W   = BLK_ADDR_W - IDX_W;
  localparam int unsigned BLK_LSB = WOFF_W + 2;

  logic [BLK_ADDR_W-1:0] blk_addr;
  logic [WOFF_W-1:0]     word_off;
  logic [IDX_W-1:0]      index;
  logic [TAG_W-1:0]      tag;
  logic [IDX_W-1:0]      fill_index;
  logic [TAG_W-1:0]      fill_tag;
  logic [TAG_W-1:0]      rd_tag;
  logic [BLOCK_W-1:0]    rd_block;
  logic                  fill_we;
  logic                  hit;
  logic                  miss;
  logic                  unused_addr;

  state_t                state_q, state_d;
  logic [SETS-1:0]       valid_q, valid_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic [WORD_W-1:0]     cpu_dout_q, cpu_dout_d;
  logic                  mem_ren_q, mem_ren_d;
  logic [BLK_ADDR_W-1:0] mem_block_address_q, mem_block_address_d;

  assign blk_addr    = cpu_addr[BLK_LSB +: BLK_ADDR_W];
  assign word_off    = cpu_addr[2 +: WOFF_W];
  assign index       = blk_addr[IDX_W-1:0];
  assign tag         = blk_addr[BLK_ADDR_W-1:IDX_W];
  assign fill_index  = mem_block_address_q[IDX_W-1:0];
  assign fill_tag    = mem_block_address_q[BLK_ADDR_W-1:IDX_W];
  assign unused_addr = ^cpu_addr[1:0];

  icache_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clock    (clock),
    .rd_index (index),
    .rd_tag   (rd_tag),
    .rd_block (rd_block),
    .we       (fill_we),
    .wr_index (fill_index),
    .wr_tag   (fill_tag),
    .wr_block (mem_dout)
  );

  always_comb begin
    state_d             = state_q;
    valid_d             = valid_q;
    flush_pend_d        = flush_pend_q;
    cpu_ready_d         = 1'b0;
    cpu_dout_d          = cpu_dout_q;
    mem_ren_d           = mem_ren_q;
    mem_block_address_d = mem_block_address_q;
    fill_we             = 1'b0;
    hit                 = 1'b0;
    miss                = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_ren) begin
          // A flush in the same cycle forces the request down the miss path.
          if (valid_q[index] && (rd_tag == tag) && !flush) begin
            hit         = 1'b1;
            cpu_ready_d = 1'b1;
            cpu_dout_d  = select_word(rd_block, word_off);
          end else begin
            miss                = 1'b1;
            state_d             = ST_MISS;
            mem_ren_d           = 1'b1;
            mem_block_address_d = blk_addr;
          end
        end
      end
      ST_MISS: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_ready) begin
          // A flush seen during the refill still returns the word but leaves the line invalid.
          fill_we = 1'b1;
          if (!flush_pend_q && !flush) valid_d[fill_index] = 1'b1;
          cpu_ready_d  = 1'b1;
          cpu_dout_d   = select_word(mem_dout, word_off);
          mem_ren_d    = 1'b0;
          flush_pend_d = 1'b0;
          state_d      = ST_RESPOND;
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q             <= ST_IDLE;
      valid_q             <= '0;
      flush_pend_q        <= 1'b0;
      cpu_ready_q         <= 1'b0;
      cpu_dout_q          <= '0;
      mem_ren_q           <= 1'b0;
      mem_block_address_q <= '0;
    end else begin
      state_q             <= state_d;
      valid_q             <= valid_d;
      flush_pend_q        <= flush_pend_d;
      cpu_ready_q         <= cpu_ready_d;
      cpu_dout_q          <= cpu_dout_d;
      mem_ren_q           <= mem_ren_d;
      mem_block_address_q <= mem_block_address_d;
    end
  end

  assign cpu_ready         = cpu_ready_q;
  assign cpu_dout          = cpu_dout_q;
  assign mem_ren           = mem_ren_q;
  assign mem_block_address = mem_block_address_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (flush) begin
      hit_count_d  = '0;
      miss_count_d = miss ? 32'd1 : '0;
    end else begin
      if (hit && (hit_count_q != '1))   hit_count_d  = hit_count_q + 32'd1;
      if (miss && (miss_count_q != '1)) miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_perf;
  assign unused_perf = hit ^ miss;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: Imem model returns word = 0x1000_0000 + byte address.
module tb_icache;
  import icache_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  cpu_ren;
  logic [31:0]           cpu_addr;
  logic                  flush;
  logic                  cpu_ready;
  logic [WORD_W-1:0]     cpu_dout;
  logic                  mem_ren;
  logic [BLK_ADDR_W-1:0] mem_block_address;
  logic                  mem_ready;
  logic [BLOCK_W-1:0]    mem_dout;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;
`endif

  int tests = 0;
  int fails = 0;
  int mem_lat = 2;
  logic stray = 1'b0;

  icache #(
    .SETS   (32),
    .ADDR_W (32)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .cpu_ren           (cpu_ren),
    .cpu_addr          (cpu_addr),
    .flush             (flush),
    .cpu_ready         (cpu_ready),
    .cpu_dout          (cpu_dout),
    .mem_ren           (mem_ren),
    .mem_block_address (mem_block_address),
    .mem_ready         (mem_ready),
    .mem_dout          (mem_dout)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count         (hit_count),
    .miss_count        (miss_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BLOCK_W-1:0] make_block(input logic [BLK_ADDR_W-1:0] b);
    logic [BLOCK_W-1:0] blk;
    for (int unsigned i = 0; i < BLOCK_WORDS; i++)
      blk[i*WORD_W +: WORD_W] = 32'h1000_0000 + {b, 4'b0000} + 32'(i * 4);
    return blk;
  endfunction

  // Imem model: answers after mem_lat+1 cycles of mem_ren, checks the address is held.
  initial begin
    int cnt;
    logic [BLK_ADDR_W-1:0] held;
    cnt       = 0;
    held      = '0;
    mem_ready = 1'b0;
    mem_dout  = '0;
    forever begin
      @(negedge clock);
      mem_ready = 1'b0;
      if (mem_ren) begin
        if (cnt == 0) held = mem_block_address;
        else check("mem addr held", 32'(mem_block_address), 32'(held));
        if (cnt == mem_lat) begin
          mem_ready = 1'b1;
          mem_dout  = make_block(mem_block_address);
          cnt       = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        if (stray) begin
          mem_ready = 1'b1;
          mem_dout  = '1;
        end
      end
    end
  end

  // flush_at: 0 = flush together with the request, n>0 = flush n cycles later, -1 = none.
  task automatic fetch(input string tag, input logic [31:0] addr, input int exp_lat,
                       input int exp_ren, input int flush_at);
    int   cyc;
    int   ren_cyc;
    int   bad_addr;
    logic got;
    @(negedge clock);
    cpu_ren  = 1'b1;
    cpu_addr = addr;
    flush    = (flush_at == 0);
    cyc      = 0;
    ren_cyc  = 0;
    bad_addr = 0;
    got      = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clock);
      cyc++;
      flush = (cyc == flush_at);
      if (mem_ren) begin
        ren_cyc++;
        if (mem_block_address !== addr[31:4]) bad_addr++;
      end
      if (cpu_ready) got = 1'b1;
    end
    flush   = 1'b0;
    cpu_ren = 1'b0;
    check({tag, " ready"}, 32'(got), 32'd1);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " dout"}, cpu_dout, 32'h1000_0000 + {addr[31:2], 2'b00});
    check({tag, " mem_ren cycles"}, ren_cyc, exp_ren);
    check({tag, " block addr"}, bad_addr, 0);
  endtask

  initial begin
    cpu_ren  = 1'b0;
    cpu_addr = '0;
    flush    = 1'b0;
    repeat (2) @(negedge clock);
    check("rst cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst mem_ren", 32'(mem_ren), 32'd0);
    check("rst cpu_dout", cpu_dout, 32'd0);
    check("rst block addr", 32'(mem_block_address), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    check("rst hit_count", hit_count, 32'd0);
    check("rst miss_count", miss_count, 32'd0);
`endif
    reset = 1'b1;

    fetch("cold 0x40", 32'h40, 4, 3, -1);

    @(negedge clock);
    cpu_ren  = 1'b1;
    cpu_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("b2b ready", 32'(cpu_ready), 32'd1);
      check("b2b dout", cpu_dout, 32'h1000_0040 + 32'(i * 4));
      check("b2b mem_ren", 32'(mem_ren), 32'd0);
      if (i < 3) cpu_addr = cpu_addr + 32'd4;
      else cpu_ren = 1'b0;
    end
`ifdef ICACHE_PERF_CNT_EN
    check("perf hit_count", hit_count, 32'd4);
    check("perf miss_count", miss_count, 32'd1);
`endif

    repeat (2) @(negedge clock);
    check("hold cpu_ready", 32'(cpu_ready), 32'd0);
    check("hold cpu_dout", cpu_dout, 32'h1000_004C);

    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    check("flush hit_count", hit_count, 32'd0);
    check("flush miss_count", miss_count, 32'd0);
`endif
    fetch("after flush 0x44", 32'h44, 4, 3, -1);
    fetch("hit 0x48", 32'h48, 1, 0, -1);
    fetch("flush+req 0x4C", 32'h4C, 4, 3, 0);

    fetch("conflict 0x240", 32'h240, 4, 3, -1);
    fetch("evicted 0x40", 32'h40, 4, 3, -1);
    fetch("refilled 0x44", 32'h44, 1, 0, -1);

    mem_lat = 4;
    fetch("flush in miss 0x80", 32'h80, 6, 5, 2);
    fetch("refetch 0x80", 32'h80, 6, 5, -1);
    fetch("hit 0x84", 32'h84, 1, 0, -1);

    @(negedge clock);
    stray = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("stray cpu_ready", 32'(cpu_ready), 32'd0);
      check("stray mem_ren", 32'(mem_ren), 32'd0);
    end
    stray = 1'b0;
    fetch("after stray 0x100", 32'h100, 6, 5, -1);
    fetch("hit 0x100", 32'h100, 1, 0, -1);

    @(negedge clock);
    cpu_ren  = 1'b1;
    cpu_addr = 32'hC0;
    repeat (2) @(negedge clock);
    check("pre-reset mem_ren", 32'(mem_ren), 32'd1);
    reset = 1'b0;
    #1;
    check("mid-miss rst mem_ren", 32'(mem_ren), 32'd0);
    check("mid-miss rst cpu_ready", 32'(cpu_ready), 32'd0);
    check("mid-miss rst cpu_dout", cpu_dout, 32'd0);
    check("mid-miss rst block addr", 32'(mem_block_address), 32'd0);
    @(negedge clock);
    reset   = 1'b1;
    cpu_ren = 1'b0;
    fetch("post-reset 0xC0", 32'hC0, 6, 5, -1);
    fetch("post-reset 0x100", 32'h100, 6, 5, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (observed running, expected done)");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter SETS, default 32, number of direct-mapped lines; power of two, 2..256.
REQ-002 Parameter ADDR_W, default 32, CPU byte-address width.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cpu_ren  input  1  fetch request; sampled only in IDLE.
REQ-006 cpu_addr  input  ADDR_W  byte address of fetch; held stable by CPU from request until cpu_ready; bits [1:0] ignored.
REQ-007 flush  input  1  one-cycle pulse invalidating all lines.
REQ-008 cpu_ready  output  1  one-cycle pulse: cpu_dout valid.
REQ-009 cpu_dout  output  `IWORD_SIZE_BITS  fetched instruction word.
REQ-010 mem_ren  output  1  block read request to Imem.
REQ-011 mem_block_address  output  `IMEM_BLOCK_ADDR_SIZE  block address to Imem.
REQ-012 mem_ready  input  1  Imem data-valid flag.
REQ-013 mem_dout  input  `IBLOCK_SIZE_BITS  Imem block data.

Function
REQ-014 Address split: offset = word-in-block bits above [1:0]; index = next log2(SETS) bits; tag = remaining bits up to block-address width.
REQ-015 Storage: per line, valid bit (flop vector), tag, `IBLOCK_SIZE_BITS data.
REQ-016 FSM states IDLE, MISS, RESPOND; IDLE->MISS on cpu_ren & miss; MISS->RESPOND on mem_ready; RESPOND->IDLE unconditionally.
REQ-017 Hit (IDLE, cpu_ren, valid & tag match): cpu_ready=1 and selected word on cpu_dout the next cycle; state stays IDLE; back-to-back hits give one word per cycle.
REQ-018 Miss: next cycle mem_ren=1, mem_block_address = cpu_addr block bits; both held constant until the cycle mem_ready is sampled 1.
REQ-019 In the mem_ready=1 cycle: mem_dout written into the line, tag written, valid set, requested word latched; mem_ren deasserted next cycle.
REQ-020 RESPOND: cpu_ready=1 with the latched word; no request accepted in RESPOND.
REQ-021 mem_ren SHALL be low for at least one cycle between consecutive refills, forcing full Imem delay each miss.
REQ-022 cpu_dout holds its last value when cpu_ready=0; cpu_ready never asserted in MISS.
REQ-023 flush in IDLE: all valid bits cleared next edge; a simultaneous cpu_ren is treated as a miss.
REQ-024 flush in MISS/RESPOND: valid bits cleared; in-flight refill completes and returns word to CPU but line is NOT marked valid.
REQ-025 mem_ready while not in MISS is ignored.

Reset
REQ-026 On reset low, asynchronously: state=IDLE, all valid bits=0, cpu_ready=0, mem_ren=0, cpu_dout=0, mem_block_address=0.
REQ-027 Reset mid-MISS abandons the refill; no line written; tag/data arrays need not be reset.

Configuration
REQ-028 Macro ICACHE_PERF_CNT_EN defined: 32-bit outputs hit_count and miss_count, reset to 0, increment on each accepted hit/miss, saturate at 0xFFFFFFFF, clear on flush.
REQ-029 Macro ICACHE_PERF_CNT_EN undefined: counters and their ports absent; behaviour otherwise identical.

Structure
REQ-030 Block/word/address widths come from the shared constants include (`IWORD_SIZE_BITS, `IBLOCK_SIZE_WORDS, `IBLOCK_SIZE_BITS, `IMEM_BLOCK_ADDR_SIZE); ICACHE index/tag width macros added there.
REQ-031 One sub-module, icache_array: SETS-entry tag+data storage, one read port (index), one write port (index, tag, block, we).

Verification
REQ-032 Cold fetch 0x0000_0040 -> miss; mem_ren high with block address 0x04 (4-word blocks) until mem_ready; cpu_ready one cycle after RESPOND entry with word from hex image.
REQ-033 Repeat fetches 0x40,0x44,0x48,0x4C after fill -> four consecutive cpu_ready pulses, one-cycle latency each, mem_ren stays 0.
REQ-034 Conflict: fetch 0x40 then 0x40+SETS*16 -> second misses and evicts; refetch 0x40 misses again.
REQ-035 flush asserted during MISS for 0x80 -> word returned, subsequent fetch 0x80 misses.
REQ-036 reset pulsed during MISS -> mem_ren=0 and cpu_ready=0 immediately; next fetch of same address misses.
REQ-037 With ICACHE_PERF_CNT_EN: scenario REQ-033 after cold miss -> hit_count=4, miss_count=1; flush -> both 0.
